// File: rtl/result_packer_pkg.sv
// Shared types and widths for the result packer: lane state encoding and
// symbol/byte/count widths used by every lane.
package result_packer_pkg;

  localparam int SYM_W  = 2;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 14;
  localparam int SLOTS  = BYTE_W / SYM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    STOP = 2'd2
  } lane_state_e;

endpackage

// File: rtl/result_packer_if.sv
// Symbol-in / byte-out bundle for the three-lane result packer.
interface result_packer_if;
  import result_packer_pkg::*;

  logic [2:0]        sym_valid;
  logic [SYM_W-1:0]  sym1, sym2, sym3;
  logic              flush;
  logic [BYTE_W-1:0] result1, result2, result3;
  logic              en1, en2, en3;
  logic [2:0]        ovf;

  modport master (
    output sym_valid, sym1, sym2, sym3, flush,
    input  result1, result2, result3, en1, en2, en3, ovf
  );

  modport slave (
    input  sym_valid, sym1, sym2, sym3, flush,
    output result1, result2, result3, en1, en2, en3, ovf
  );
endinterface

// File: rtl/result_packer_pack_lane.sv
// One packing lane: collects four 2-bit symbols LSB-first into a byte,
// pads on flush, and stops accepting once the downstream buffer is full.
module pack_lane
  import result_packer_pkg::*;
#(
  parameter logic [SYM_W-1:0] PAD_SYM   = 2'b11,
  parameter int               MAX_BYTES = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [SYM_W-1:0]  sym,
  input  logic              flush,
  output logic [BYTE_W-1:0] result,
  output logic              en,
  output logic              ovf
);

  lane_state_e       state;
  logic [BYTE_W-1:0] acc;
  logic [1:0]        npend;
  logic [CNT_W-1:0]  count;

  logic [BYTE_W-1:0] out_byte;
  logic [2:0]        pend_next;
  logic              emit;
  logic              at_limit;

  // The incoming symbol lands in the next free slot before any flush is
  // considered; slots beyond the pending ones are filled with PAD_SYM.
  always_comb begin
    out_byte = acc;
    if (valid) out_byte[{npend, 1'b0} +: SYM_W] = sym;
    pend_next = {1'b0, npend} + {2'b00, valid};
    for (int i = 0; i < SLOTS; i++) begin
      if (3'(i) >= pend_next) out_byte[i*SYM_W +: SYM_W] = PAD_SYM;
    end
    emit     = pend_next[2] || (flush && (pend_next != 3'd0));
    at_limit = ({{(32-CNT_W){1'b0}}, count} + 32'd1) == 32'(MAX_BYTES);
  end

  // The count saturates at its all-ones value; STOP is entered by comparing
  // against MAX_BYTES in a wider domain so the 14-bit counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      npend  <= '0;
      count  <= '0;
      result <= '0;
      en     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      en <= 1'b0;
      if (state == STOP) begin
        if (valid) ovf <= 1'b1;
      end else if (emit) begin
        result <= out_byte;
        en     <= 1'b1;
        acc    <= '0;
        npend  <= '0;
        if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
        state  <= at_limit ? STOP : IDLE;
      end else if (valid) begin
        acc   <= out_byte;
        npend <= pend_next[1:0];
        state <= ACC;
      end
    end
  end

endmodule

// File: rtl/result_packer.sv
// Three independent packing lanes sharing one flush; wiring only.
module result_packer
  import result_packer_pkg::*;
#(
  parameter logic [SYM_W-1:0] PAD_SYM   = 2'b11,
  parameter int               MAX_BYTES = 16384
) (
  input  logic      clk,
  input  logic      reset,
  result_packer_if.slave bus
);

  logic [2:0] ovf_w;

  pack_lane #(.PAD_SYM(PAD_SYM), .MAX_BYTES(MAX_BYTES)) u_lane1 (
    .clk(clk), .reset(reset), .valid(bus.sym_valid[0]), .sym(bus.sym1),
    .flush(bus.flush), .result(bus.result1), .en(bus.en1), .ovf(ovf_w[0])
  );

  pack_lane #(.PAD_SYM(PAD_SYM), .MAX_BYTES(MAX_BYTES)) u_lane2 (
    .clk(clk), .reset(reset), .valid(bus.sym_valid[1]), .sym(bus.sym2),
    .flush(bus.flush), .result(bus.result2), .en(bus.en2), .ovf(ovf_w[1])
  );

  pack_lane #(.PAD_SYM(PAD_SYM), .MAX_BYTES(MAX_BYTES)) u_lane3 (
    .clk(clk), .reset(reset), .valid(bus.sym_valid[2]), .sym(bus.sym3),
    .flush(bus.flush), .result(bus.result3), .en(bus.en3), .ovf(ovf_w[2])
  );

  assign bus.ovf = ovf_w;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: one default-limit instance and one
// instance with a two-byte limit for the overflow path.
module tb_result_packer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  result_packer_if busA ();
  result_packer_if busB ();

  result_packer #(.PAD_SYM(2'b11), .MAX_BYTES(16384)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave)
  );

  result_packer #(.PAD_SYM(2'b11), .MAX_BYTES(2)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs on bus A, then waits past the edge so the
  // registered outputs can be sampled.
  task automatic applyStimulus(input logic [2:0] v, input logic [1:0] s1,
                               input logic [1:0] s2, input logic [1:0] s3,
                               input logic fl);
    busA.sym_valid = v;
    busA.sym1 = s1;
    busA.sym2 = s2;
    busA.sym3 = s3;
    busA.flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] l1 [8];
    logic [1:0] l2 [8];
    logic [1:0] l3 [8];
    logic [7:0] e1 [2];
    logic [7:0] e2 [2];
    logic [7:0] e3 [2];
    bit         expEn;

    l1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    l2 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    l3 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    e1 = '{8'hE4, 8'h1B};
    e2 = '{8'h55, 8'hAA};
    e3 = '{8'hFF, 8'h00};

    busB.sym_valid = 3'b000;
    busB.sym1 = 2'd0;
    busB.sym2 = 2'd0;
    busB.sym3 = 2'd0;
    busB.flush = 1'b0;

    // Reset state, with valid and flush active to show reset wins.
    reset = 1'b1;
    applyStimulus(3'b111, 2'd1, 2'd2, 2'd3, 1'b1);
    applyStimulus(3'b111, 2'd1, 2'd2, 2'd3, 1'b1);
    checkOutput("rst_result1", busA.result1, 8'h00);
    checkOutput("rst_result2", busA.result2, 8'h00);
    checkOutput("rst_result3", busA.result3, 8'h00);
    checkOutput("rst_en", {5'b0, busA.en3, busA.en2, busA.en1}, 8'h00);
    checkOutput("rst_ovf", {5'b0, busA.ovf}, 8'h00);
    reset = 1'b0;

    // Lane 1: 0,1,2,3 packs to E4 one cycle after the fourth symbol.
    applyStimulus(3'b001, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("l1_byte_s1_en", {7'b0, busA.en1}, 8'h00);
    applyStimulus(3'b001, 2'd1, 2'd0, 2'd0, 1'b0);
    checkOutput("l1_byte_s2_en", {7'b0, busA.en1}, 8'h00);
    applyStimulus(3'b001, 2'd2, 2'd0, 2'd0, 1'b0);
    checkOutput("l1_byte_s3_en", {7'b0, busA.en1}, 8'h00);
    applyStimulus(3'b001, 2'd3, 2'd0, 2'd0, 1'b0);
    checkOutput("l1_byte_en", {7'b0, busA.en1}, 8'h01);
    checkOutput("l1_byte_result", busA.result1, 8'hE4);
    applyStimulus(3'b000, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("l1_byte_en_drop", {7'b0, busA.en1}, 8'h00);
    checkOutput("l1_byte_hold", busA.result1, 8'hE4);

    // Lane 2: 1,2 then flush pads the upper slots; a second flush is silent.
    applyStimulus(3'b010, 2'd0, 2'd1, 2'd0, 1'b0);
    applyStimulus(3'b010, 2'd0, 2'd2, 2'd0, 1'b0);
    checkOutput("l2_pre_flush_en", {7'b0, busA.en2}, 8'h00);
    applyStimulus(3'b000, 2'd0, 2'd0, 2'd0, 1'b1);
    checkOutput("l2_flush_en", {5'b0, busA.en3, busA.en2, busA.en1}, 8'h02);
    checkOutput("l2_flush_result", busA.result2, 8'hF9);
    applyStimulus(3'b000, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("l2_flush_en_drop", {7'b0, busA.en2}, 8'h00);
    applyStimulus(3'b000, 2'd0, 2'd0, 2'd0, 1'b1);
    checkOutput("l2_idle_flush_en", {5'b0, busA.en3, busA.en2, busA.en1}, 8'h00);

    // Lane 3: fourth symbol coincides with flush, giving a single full byte.
    applyStimulus(3'b100, 2'd0, 2'd0, 2'd2, 1'b0);
    applyStimulus(3'b100, 2'd0, 2'd0, 2'd2, 1'b0);
    applyStimulus(3'b100, 2'd0, 2'd0, 2'd2, 1'b0);
    applyStimulus(3'b100, 2'd0, 2'd0, 2'd2, 1'b1);
    checkOutput("l3_flush4_en", {5'b0, busA.en3, busA.en2, busA.en1}, 8'h04);
    checkOutput("l3_flush4_result", busA.result3, 8'hAA);
    applyStimulus(3'b000, 2'd0, 2'd0, 2'd0, 1'b0);
    checkOutput("l3_flush4_single", {7'b0, busA.en3}, 8'h00);

    // Reset after three lane-1 symbols discards the partial byte.
    applyStimulus(3'b001, 2'd3, 2'd0, 2'd0, 1'b0);
    applyStimulus(3'b001, 2'd3, 2'd0, 2'd0, 1'b0);
    applyStimulus(3'b001, 2'd3, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    applyStimulus(3'b001, 2'd3, 2'd0, 2'd0, 1'b1);
    checkOutput("rst_mid_en", {7'b0, busA.en1}, 8'h00);
    checkOutput("rst_mid_result", busA.result1, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b001, 2'd1, 2'd0, 2'd0, 1'b0);
      checkOutput($sformatf("rst_mid_en_s%0d", i), {7'b0, busA.en1}, (i == 3) ? 8'h01 : 8'h00);
    end
    checkOutput("rst_mid_result_55", busA.result1, 8'h55);

    // All lanes fed on identical cycles produce coincident pulses.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b111, l1[i], l2[i], l3[i], 1'b0);
      expEn = (i == 3) || (i == 7);
      checkOutput($sformatf("all_en_s%0d", i), {5'b0, busA.en3, busA.en2, busA.en1},
                  expEn ? 8'h07 : 8'h00);
      if (expEn) begin
        checkOutput($sformatf("all_r1_s%0d", i), busA.result1, e1[i/4]);
        checkOutput($sformatf("all_r2_s%0d", i), busA.result2, e2[i/4]);
        checkOutput($sformatf("all_r3_s%0d", i), busA.result3, e3[i/4]);
      end
    end
    applyStimulus(3'b000, 2'd0, 2'd0, 2'd0, 1'b0);

    // Two-byte limit on instance B: the ninth symbol is dropped and flags ovf.
    for (int i = 0; i < 12; i++) begin
      busB.sym_valid = 3'b001;
      busB.sym1 = 2'd1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("lim_en_s%0d", i), {7'b0, busB.en1},
                  ((i == 3) || (i == 7)) ? 8'h01 : 8'h00);
      checkOutput($sformatf("lim_ovf_s%0d", i), {5'b0, busB.ovf}, (i >= 8) ? 8'h01 : 8'h00);
    end
    busB.sym_valid = 3'b000;
    busB.flush = 1'b1;
    @(posedge clk);
    #1;
    busB.flush = 1'b0;
    checkOutput("lim_stop_flush_en", {7'b0, busB.en1}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("lim_ovf_sticky", {5'b0, busB.ovf}, 8'h01);
    checkOutput("lim_result_hold", busB.result1, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
